// File: rtl/dnn_pkg.sv
// Shared constants, state encoding and slot mapping for the dnn_feeder block.
// Optional timeout behaviour is enabled with the DNN_FEED_TIMEOUT_EN macro.
package dnn_pkg;

  localparam int DW  = 5;   // input / weight word width
  localparam int OW  = 17;  // core result width
  localparam int NW  = 24;  // words per weight frame
  localparam int NX  = 4;   // words per input frame

  // Weight stream order: layer-1 words first, then layer-2 words.
  localparam int NW1     = 16;
  localparam int NW2     = 8;
  localparam int W1_BASE = 0;    // stream index of dnn_w1 word 0 (w04)
  localparam int W2_BASE = NW1;  // stream index of dnn_w2 word 0 (w48)

  localparam int CW = $clog2(NW);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_X,
    ST_FIRE,
    ST_WAIT_CLR,
    ST_WAIT_SET,
    ST_RESULT
  } feed_state_t;

  // Index of the final word of a frame (kind 0 = weights, 1 = inputs).
  function automatic logic [CW-1:0] frame_last(input logic kind);
    return kind ? CW'(NX - 1) : CW'(NW - 1);
  endfunction

endpackage

// File: rtl/dnn_feeder_if.sv
// Stream-in and result-out handshake bundle of dnn_feeder.
// The feeder uses the slave view; the word source / result sink uses master.
interface dnn_feeder_if;
  import dnn_pkg::*;

  logic                 s_valid;
  logic                 s_ready;
  logic                 s_kind;
  logic signed [DW-1:0] s_data;

  logic                 r_valid;
  logic                 r_ready;
  logic signed [OW-1:0] r_data0;
  logic signed [OW-1:0] r_data1;
  logic                 r_err;

  modport master (
    output s_valid, s_kind, s_data, r_ready,
    input  s_ready, r_valid, r_data0, r_data1, r_err
  );

  modport slave (
    input  s_valid, s_kind, s_data, r_ready,
    output s_ready, r_valid, r_data0, r_data1, r_err
  );

endinterface

// File: rtl/dnn_frame_loader.sv
// Word counter and bus write logic: steers each accepted stream word into
// its slot on the x / w1 / w2 parallel buses. Words pass through bit-exact.
module dnn_frame_loader
  import dnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr,     // word accepted this cycle
  input  logic                 i_first,  // accepted word opens a new frame
  input  logic                 i_kind,   // frame kind, meaningful with i_first
  input  logic signed [DW-1:0] i_data,
  output logic                 o_last,   // accepted word closes the frame
  output logic [NX*DW-1:0]     o_x,
  output logic [NW1*DW-1:0]    o_w1,
  output logic [NW2*DW-1:0]    o_w2
);

  logic [CW-1:0]     r_cnt;
  logic              r_kind;
  logic [NX*DW-1:0]  r_x;
  logic [NW1*DW-1:0] r_w1;
  logic [NW2*DW-1:0] r_w2;

  logic              w_kind;
  logic [CW-1:0]     w_idx;

  // The first word of a frame always lands in slot 0 with the live kind bit.
  assign w_kind = i_first ? i_kind : r_kind;
  assign w_idx  = i_first ? '0     : r_cnt;
  assign o_last = i_wr && !i_first && (r_cnt == frame_last(r_kind));

  assign o_x  = r_x;
  assign o_w1 = r_w1;
  assign o_w2 = r_w2;

  // Track frame kind and the slot index of the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_kind <= 1'b0;
    end else if (i_wr) begin
      r_cnt <= o_last ? '0 : w_idx + CW'(1);
      if (i_first) r_kind <= i_kind;
    end
  end

  // Write the accepted word into its bus slot; all other slots hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_w1 <= '0;
      r_w2 <= '0;
    end else if (i_wr) begin
      if (w_kind) begin
        for (int k = 0; k < NX; k++)
          if (w_idx == CW'(k)) r_x[k*DW +: DW] <= i_data;
      end else begin
        for (int k = 0; k < NW1; k++)
          if (w_idx == CW'(W1_BASE + k)) r_w1[k*DW +: DW] <= i_data;
        for (int k = 0; k < NW2; k++)
          if (w_idx == CW'(W2_BASE + k)) r_w2[k*DW +: DW] <= i_data;
      end
    end
  end

endmodule

// File: rtl/dnn_feeder.sv
// Driver for the 4-4-2 DNN core: assembles weight / input frames from a
// serial stream, strobes the core, waits on its sticky ready flags and
// returns the results on a valid/ready port.
// Optional: define DNN_FEED_TIMEOUT_EN to bound the wait for the core flags.
module dnn_feeder
  import dnn_pkg::*;
#(
  parameter int IN_HOLD = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dnn_feeder_if.slave          bus,
  output logic [NX*DW-1:0]     dnn_x,
  output logic [NW1*DW-1:0]    dnn_w1,
  output logic [NW2*DW-1:0]    dnn_w2,
  output logic                 dnn_in_ready,
  input  logic signed [OW-1:0] dnn_out0,
  input  logic signed [OW-1:0] dnn_out1,
  input  logic                 dnn_out0_ready,
  input  logic                 dnn_out1_ready
);

  localparam int HW = $clog2(IN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(IN_HOLD - 1);

  // The core needs the strobe for at least two of its edges to clear its flags.
  if (IN_HOLD < 2) begin : g_bad_hold
    $error("dnn_feeder: IN_HOLD must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("dnn_feeder: TIMEOUT must be at least 1");
  end

  feed_state_t   r_state;
  logic [HW-1:0] r_hold;

  logic w_acc;
  logic w_first;
  logic w_last;

`ifdef DNN_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;
  assign bus.r_err = r_err;
`else
  assign bus.r_err = 1'b0;
`endif

  // s_ready is only high in IDLE/LOAD states, so an accepted word is always
  // a frame word and the buses cannot move between FIRE and RESULT exit.
  assign w_acc   = bus.s_valid & bus.s_ready;
  assign w_first = (r_state == ST_IDLE);

  dnn_frame_loader u_loader (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_acc),
    .i_first (w_first),
    .i_kind  (bus.s_kind),
    .i_data  (bus.s_data),
    .o_last  (w_last),
    .o_x     (dnn_x),
    .o_w1    (dnn_w1),
    .o_w2    (dnn_w2)
  );

  // Sequencing FSM with registered handshake, strobe and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      bus.s_ready  <= 1'b1;
      dnn_in_ready <= 1'b0;
      bus.r_valid  <= 1'b0;
      bus.r_data0  <= '0;
      bus.r_data1  <= '0;
`ifdef DNN_FEED_TIMEOUT_EN
      r_tmo        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) r_state <= bus.s_kind ? ST_LOAD_X : ST_LOAD_W;
        end

        ST_LOAD_W: begin
          if (w_last) r_state <= ST_IDLE;
        end

        ST_LOAD_X: begin
          if (w_last) begin
            r_state      <= ST_FIRE;
            bus.s_ready  <= 1'b0;
            dnn_in_ready <= 1'b1;
            r_hold       <= '0;
          end
        end

        ST_FIRE: begin
          if (r_hold == HOLD_LAST) begin
            dnn_in_ready <= 1'b0;
            r_state      <= ST_WAIT_CLR;
`ifdef DNN_FEED_TIMEOUT_EN
            r_tmo        <= '0;
`endif
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end

        // A flag still high here is stale; wait until the core clears it.
        ST_WAIT_CLR: begin
          if (!dnn_out0_ready) begin
            r_state <= ST_WAIT_SET;
`ifdef DNN_FEED_TIMEOUT_EN
            r_tmo   <= r_tmo + TW'(1);
          end else if (r_tmo == TMO_LAST) begin
            r_state     <= ST_RESULT;
            bus.r_valid <= 1'b1;
            bus.r_data0 <= '0;
            bus.r_data1 <= '0;
            r_err       <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
`endif
          end
        end

        ST_WAIT_SET: begin
          if (dnn_out0_ready && dnn_out1_ready) begin
            r_state     <= ST_RESULT;
            bus.r_valid <= 1'b1;
            bus.r_data0 <= dnn_out0;
            bus.r_data1 <= dnn_out1;
`ifdef DNN_FEED_TIMEOUT_EN
            r_err       <= 1'b0;
          end else if (r_tmo == TMO_LAST) begin
            r_state     <= ST_RESULT;
            bus.r_valid <= 1'b1;
            bus.r_data0 <= '0;
            bus.r_data1 <= '0;
            r_err       <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
`endif
          end
        end

        ST_RESULT: begin
          if (bus.r_ready) begin
            bus.r_valid <= 1'b0;
            bus.s_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          bus.s_ready  <= 1'b1;
          dnn_in_ready <= 1'b0;
          bus.r_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_feeder.sv
// Directed bench for dnn_feeder with a small behavioural 4-4-2 core model.
// The timeout section runs only when DNN_FEED_TIMEOUT_EN is defined.
module tb_dnn_feeder;
  import dnn_pkg::*;

  localparam int IN_HOLD = 2;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst_n;

  logic [NX*DW-1:0]     dnn_x;
  logic [NW1*DW-1:0]    dnn_w1;
  logic [NW2*DW-1:0]    dnn_w2;
  logic                 dnn_in_ready;
  logic signed [OW-1:0] c_out0 = '0;
  logic signed [OW-1:0] c_out1 = '0;
  logic                 c_rdy0 = 1'b0;
  logic                 c_rdy1 = 1'b0;
  logic                 force_hi = 1'b0;
  logic                 w_rdy0, w_rdy1;

  int n_tests = 0;
  int n_fail  = 0;

  dnn_feeder_if bus ();

  assign w_rdy0 = c_rdy0 | force_hi;
  assign w_rdy1 = c_rdy1 | force_hi;

  dnn_feeder #(.IN_HOLD(IN_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dnn_x          (dnn_x),
    .dnn_w1         (dnn_w1),
    .dnn_w2         (dnn_w2),
    .dnn_in_ready   (dnn_in_ready),
    .dnn_out0       (c_out0),
    .dnn_out1       (c_out1),
    .dnn_out0_ready (w_rdy0),
    .dnn_out1_ready (w_rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural core (never reset by the feeder) ----------
  logic prev_ir = 1'b0;
  int   ccnt = 0;
  int   pend0 = 0, pend1 = 0;

  function automatic void core_eval(input logic [NX*DW-1:0] x,
                                    input logic [NW1*DW-1:0] w1,
                                    input logic [NW2*DW-1:0] w2,
                                    output int o0, output int o1);
    int h;
    o0 = 0;
    o1 = 0;
    for (int j = 0; j < 4; j++) begin
      h = 0;
      for (int i = 0; i < 4; i++)
        h += int'($signed(x[i*DW +: DW])) * int'($signed(w1[(4*i+j)*DW +: DW]));
      if (h < 0) h = 0;
      o0 += h * int'($signed(w2[(2*j)*DW +: DW]));
      o1 += h * int'($signed(w2[(2*j+1)*DW +: DW]));
    end
  endfunction

  always @(posedge clk) begin
    int e0, e1;
    prev_ir <= dnn_in_ready;
    if (dnn_in_ready && !prev_ir) begin
      core_eval(dnn_x, dnn_w1, dnn_w2, e0, e1);
      pend0 <= e0;
      pend1 <= e1;
      ccnt  <= 1;
    end else if (ccnt != 0) begin
      if (ccnt == 1) begin
        c_rdy0 <= 1'b0;
        c_rdy1 <= 1'b0;
      end
      if (ccnt == 5) begin
        c_out0 <= OW'(pend0);
        c_out1 <= OW'(pend1);
        c_rdy0 <= 1'b1;
        c_rdy1 <= 1'b1;
        ccnt   <= 0;
      end else begin
        ccnt <= ccnt + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic signed [127:0] got,
                       input logic signed [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic kind, input int val);
    int n;
    n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_kind  = kind;
    bus.s_data  = DW'(val);
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) check("s_accept_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic load_weights(input int w [NW]);
    for (int k = 0; k < NW; k++) send_word(1'b0, w[k]);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Sends an input frame and counts cycles from the last accept to r_valid.
  task automatic run_x(input int x0, input int x1, input int x2, input int x3,
                       output int lat);
    send_word(1'b1, x0);
    send_word(1'b1, x1);
    send_word(1'b1, x2);
    send_word(1'b1, x3);
    lat = 0;
    do begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      lat++;
    end while (!bus.r_valid && lat < 300);
    if (!bus.r_valid) check("r_valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int wv [NW];
  int lat;
  logic [NW1*DW-1:0] exp_w1;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_kind  = 1'b0;
    bus.s_data  = '0;
    bus.r_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_s_ready", bus.s_ready, 1);
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_r_err", bus.r_err, 0);
    check("rst_in_ready", dnn_in_ready, 0);
    check("rst_x", dnn_x, 0);
    check("rst_w1", dnn_w1, 0);
    check("rst_w2", dnn_w2, 0);
    check("rst_r_data0", bus.r_data0, 0);
    rst_n = 1'b1;

    // Weight frame, all ones.
    for (int k = 0; k < NW; k++) wv[k] = 1;
    exp_w1 = '0;
    for (int k = 0; k < NW1; k++) exp_w1[k*DW +: DW] = 5'd1;
    load_weights(wv);
    check("w_frame_no_result", bus.r_valid, 0);
    check("w_frame_s_ready", bus.s_ready, 1);
    check("w1_bus_ones", dnn_w1, exp_w1);
    check("w2_bus_ones", dnn_w2, 40'h0842108421);

    // x = 1,2,3,4 -> 40 / 40, then hold r_ready low for 10 cycles.
    run_x(1, 2, 3, 4, lat);
    check("lat_1234", lat, 8);
    check("x_bus_1234", dnn_x, 20'd134209);
    check("r_data0_1234", bus.r_data0, 40);
    check("r_data1_1234", bus.r_data1, 40);
    check("r_err_1234", bus.r_err, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_r_valid", bus.r_valid, 1);
      check("stall_r_data0", bus.r_data0, 40);
      check("stall_s_ready", bus.s_ready, 0);
    end
    handshake();
    check("post_hs_r_valid", bus.r_valid, 0);
    check("post_hs_s_ready", bus.s_ready, 1);

    // x = -1 x4: layer-1 ReLU clamps everything to zero.
    run_x(-1, -1, -1, -1, lat);
    check("lat_neg", lat, 8);
    check("x_bus_neg", dnn_x, 20'hFFFFF);
    check("r_data0_neg", bus.r_data0, 0);
    check("r_data1_neg", bus.r_data1, 0);
    handshake();

    // w1 = 1, w48 = 2, w49 = -3, rest of w2 = 0; x = 1 x4 -> 8 / -12.
    for (int k = 0; k < NW; k++) wv[k] = (k < NW1) ? 1 : 0;
    wv[W2_BASE]     = 2;
    wv[W2_BASE + 1] = -3;
    load_weights(wv);
    check("w2_bus_order", dnn_w2, 40'd930);
    run_x(1, 1, 1, 1, lat);
    check("r_data0_order", bus.r_data0, 8);
    check("r_data1_order", bus.r_data1, -12);
    handshake();

    // Reset the feeder in WAIT_SET; the core later raises stale flags.
    send_word(1'b1, 2);
    send_word(1'b1, 2);
    send_word(1'b1, 2);
    send_word(1'b1, 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    check("pre_rst_r_valid", bus.r_valid, 0);
    check("pre_rst_s_ready", bus.s_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_x", dnn_x, 0);
    check("mid_rst_w2", dnn_w2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < NW; k++) wv[k] = 1;
    load_weights(wv);
    run_x(1, 2, 3, 4, lat);
    check("lat_after_rst", lat, 8);
    check("r_data0_after_rst", bus.r_data0, 40);
    check("r_data1_after_rst", bus.r_data1, 40);
    handshake();

`ifdef DNN_FEED_TIMEOUT_EN
    // Core flags stuck high: WAIT_CLR never clears, the timeout fires.
    force_hi = 1'b1;
    run_x(1, 2, 3, 4, lat);
    check("tmo_lat", lat, 1 + IN_HOLD + TIMEOUT);
    check("tmo_r_valid", bus.r_valid, 1);
    check("tmo_r_err", bus.r_err, 1);
    check("tmo_r_data0", bus.r_data0, 0);
    check("tmo_r_data1", bus.r_data1, 0);
    handshake();
    force_hi = 1'b0;
    check("tmo_post_s_ready", bus.s_ready, 1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
